uart_echo_core: RTL and testbench



---
 rtl/uart_echo_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_echo_core.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_core.sv
// uart_echo_core: 8N1 UART receiver -> byte FIFO -> 8N1 transmitter echo, last good byte on LEDs.
// Latency: rx_valid at stop-bit centre; FIFO write that cycle, TX pop next cycle, usb_tx start bit the cycle after.
// Backpressure: none towards the line; a push into a full FIFO is dropped and latches the sticky ovf flag.
//
// Ports: clk (system clock), rst_n (async active-low reset), usb_rx (serial in, idle high, async),
//        usb_tx (registered serial out, idle high), led[LED_W-1:0] (low bits of last good received byte).
// Optional feature macro: UART_ECHO_CASE_SWAP_EN -- invert bit 5 of ASCII letters before they enter the FIFO.
module uart_echo_core #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 1000000,
    parameter int FIFO_DEPTH = 16,
    parameter int LED_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             usb_rx,
    output logic             usb_tx,
    output logic [LED_W-1:0] led
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    // ---------------- RX path ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    rx_state_t     rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic          rx_meta, rx_s;
    logic          rx_valid;
    logic          rx_tick;
    logic [7:0]    last_byte;

    // The counter is "cycles left including this one", so the sample cycle is the one where it reads 1.
    assign rx_tick = (rx_cnt == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            last_byte <= '0;
        end else begin
            rx_meta  <= usb_rx;
            rx_s     <= rx_meta;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            if (rx_valid) begin
                last_byte <= rx_shift;
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt - CNT_ONE;
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;          // line back high at mid start bit: glitch
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = CNT_BIT;
                        rx_bit_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt - CNT_ONE;
                if (rx_tick) begin
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    rx_cnt_d   = CNT_BIT;
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_cnt - CNT_ONE;
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_valid   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;     // framing error or break: drop byte
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign led = last_byte[LED_W-1:0];

    // ---------------- optional case swap ----------------
    logic [7:0] push_dat;
`ifdef UART_ECHO_CASE_SWAP_EN
    always_comb begin
        push_dat = rx_shift;
        if ((rx_shift >= 8'h41 && rx_shift <= 8'h5A) || (rx_shift >= 8'h61 && rx_shift <= 8'h7A)) begin
            push_dat[5] = ~rx_shift[5];
        end
    end
`else
    assign push_dat = rx_shift;
`endif

    // ---------------- echo FIFO ----------------
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        fifo_empty, fifo_full, push_ok, tx_pop, ovf;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted then.
    assign push_ok    = rx_valid && (!fifo_full || tx_pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (tx_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            ovf <= ovf | (rx_valid & fifo_full & ~tx_pop);
        end
    end

    // ---------------- TX path ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          tx_out, tx_out_d;

    // Pop only from IDLE with data present; this also blocks a pop on an empty FIFO during a push.
    assign tx_pop = (tx_state == TX_IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_out   <= tx_out_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt - CNT_ONE;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_out_d   = tx_out;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = tx_cnt;
                tx_out_d = 1'b1;
                if (tx_pop) begin
                    tx_state_d = TX_START;
                    tx_shift_d = mem[rptr[AW-1:0]];
                    tx_cnt_d   = CNT_LAST;
                    tx_out_d   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_LAST;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d = CNT_LAST;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_out_d   = tx_shift[1];
                        tx_bit_d   = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                // Leave one cycle early: the IDLE cycle completes the stop bit, so a queued
                // byte starts exactly one bit time after the stop bit began.
                if (tx_cnt == CNT_ONE) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign usb_tx = tx_out;

endmodule

// File: tb/tb_uart_echo_core.sv
module tb_uart_echo_core;
    localparam int CPB  = 100;   // main instance: 100 MHz / 1 Mbaud
    localparam int CPB2 = 8;     // overflow instance: 100 MHz / 12.5 Mbaud

    logic       clk = 1'b0;
    logic       rst_n;
    logic       usb_rx, usb_rx2;
    logic       usb_tx, usb_tx2;
    logic [7:0] led, led2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rst_epoch = 0;
    int send_start = 0;
    int rxv_cyc = 0;
    int rxv_cnt = 0;
    logic rxv_prev = 1'b0;
    logic [7:0] led_at_rxv = 8'h00;
    logic [7:0] led_after_rxv = 8'h00;

    logic [8:0] got_q[$], got2_q[$], exp_q[$], exp2_q[$];
    int start_q[$];

    uart_echo_core dut (
        .clk(clk), .rst_n(rst_n), .usb_rx(usb_rx), .usb_tx(usb_tx), .led(led)
    );

    uart_echo_core #(.CLK_HZ(100000000), .BAUD(12500000), .FIFO_DEPTH(2), .LED_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .usb_rx(usb_rx2), .usb_tx(usb_tx2), .led(led2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_epoch++;

    always @(negedge clk) begin
        if (rxv_prev) led_after_rxv = led;
        rxv_prev = 1'b0;
        if (dut.rx_valid === 1'b1) begin
            rxv_cyc = cyc;
            rxv_cnt++;
            led_at_rxv = led;
            rxv_prev = 1'b1;
        end
    end

    function automatic logic [7:0] exp_echo(input logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return b ^ 8'h20;
`endif
        return b;
    endfunction

    function automatic logic tx_line(input int which);
        return (which == 0) ? usb_tx : usb_tx2;
    endfunction

    // Decodes frames on a TX line into {stop, data}; frames cut by reset are discarded.
    task automatic tx_monitor(input int which, input int cpb);
        logic [8:0] fr;
        int t0, ep;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_line(which) === 1'b0) begin
                t0 = cyc;
                ep = rst_epoch;
                repeat (cpb / 2) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    repeat (cpb) @(negedge clk);
                    fr[i] = tx_line(which);
                end
                if (ep == rst_epoch) begin
                    if (which == 0) begin
                        got_q.push_back(fr);
                        start_q.push_back(t0);
                    end else begin
                        got2_q.push_back(fr);
                    end
                end
            end
        end
    endtask

    initial tx_monitor(0, CPB);
    initial tx_monitor(1, CPB2);

    task automatic set_rx(input int which, input logic v);
        if (which == 0) usb_rx = v;
        else usb_rx2 = v;
    endtask

    // frame = {stop, data[7:0], start}; called and returns at posedge+1
    task automatic send_frame(input int which, input int cpb, input logic [9:0] frame);
        send_start = cyc;
        for (int i = 0; i < 10; i++) begin
            set_rx(which, frame[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int which, input int n, input int budget, output bit ok);
        int k = 0;
        while (((which == 0) ? got_q.size() : got2_q.size()) < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (((which == 0) ? got_q.size() : got2_q.size()) >= n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        usb_rx = 1'b1;
        usb_rx2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 usb_rx = i[0];
            @(negedge clk);
            n_tests++;
            if (usb_tx !== 1'b1 || led !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: usb_tx=%b led=%h, expected usb_tx=1 led=00", i, usb_tx, led);
            end
        end
        usb_rx = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1200);
        n_tests++;
        if (rxv_cnt !== 0 || got_q.size() !== 0 || usb_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_echo: rx_valid count=%0d echoes=%0d usb_tx=%b, expected 0 0 1",
                     rxv_cnt, got_q.size(), usb_tx);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [8:0] g, e;
        int st;
        exp_q.push_back({1'b1, exp_echo(8'h61)});
        send_frame(0, CPB, {1'b1, 8'h61, 1'b0});
        wait_frames(0, 1, 3000, ok);
        n_tests++;
        if (rxv_cyc - send_start !== (19 * CPB) / 2 + 2) begin
            n_fail++;
            $display("FAIL single_rx_latency: %0d cycles, expected %0d", rxv_cyc - send_start, (19 * CPB) / 2 + 2);
        end
        n_tests++;
        if (led_at_rxv !== 8'h00 || led_after_rxv !== 8'h61) begin
            n_fail++;
            $display("FAIL single_led_timing: at rx_valid %h, next cycle %h, expected 00 then 61", led_at_rxv, led_after_rxv);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_echo: timeout, 0 frames, expected 1");
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            st = start_q.pop_front();
            if (g !== e) begin
                n_fail++;
                $display("FAIL single_echo: got %h, expected %h", g, e);
            end
            n_tests++;
            if (st - rxv_cyc !== 2) begin
                n_fail++;
                $display("FAIL single_tx_latency: start edge %0d cycles after rx_valid, expected 2", st - rxv_cyc);
            end
        end
        n_tests++;
        if (led !== 8'h61) begin
            n_fail++;
            $display("FAIL single_led: %h, expected 61", led);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [8:0] g, e;
        int st[32];
        for (int b = 0; b < 32; b++) begin
            exp_q.push_back({1'b1, exp_echo(8'(b))});
            send_frame(0, CPB, {1'b1, 8'(b), 1'b0});
        end
        wait_frames(0, 32, 3000, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_count: %0d frames, expected 32", got_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                st[i] = start_q.pop_front();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got %h, expected %h", i, g, e);
                end
                if (i > 0) begin
                    n_tests++;
                    if (st[i] - st[i-1] !== 10 * CPB) begin
                        n_fail++;
                        $display("FAIL b2b_gap[%0d]: %0d cycles, expected %0d", i, st[i] - st[i-1], 10 * CPB);
                    end
                end
            end
        end
        exp_q.delete();
        n_tests++;
        if (dut.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ovf: %b, expected 0", dut.ovf);
        end
    endtask

    task automatic test_framing();
        bit ok;
        logic [8:0] g, e;
        logic [7:0] prior;
        int rxv0;
        prior = led;
        rxv0 = rxv_cnt;
        send_frame(0, CPB, {1'b0, 8'h55, 1'b0});
        usb_rx = 1'b0;
        idle(30 * CPB);
        usb_rx = 1'b1;
        idle(2 * CPB);
        n_tests++;
        if (led !== prior || rxv_cnt !== rxv0 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL framing_drop: led=%h rx_valid count=%0d echoes=%0d, expected led=%h count=%0d echoes=0",
                     led, rxv_cnt, got_q.size(), prior, rxv0);
        end
        exp_q.push_back({1'b1, exp_echo(8'h3C)});
        send_frame(0, CPB, {1'b1, 8'h3C, 1'b0});
        wait_frames(0, 1, 3000, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL framing_recover: timeout, 0 frames, expected 1");
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            void'(start_q.pop_front());
            if (g !== e) begin
                n_fail++;
                $display("FAIL framing_recover: got %h, expected %h", g, e);
            end
        end
        n_tests++;
        if (led !== 8'h3C) begin
            n_fail++;
            $display("FAIL framing_led: %h, expected 3c", led);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [8:0] g, e;
        logic [7:0] bytes[4];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
        force dut2.tx_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // depth 2 and no drain: only the first two pushes can land
            if (i < 2) exp2_q.push_back({1'b1, bytes[i]});
            send_frame(1, CPB2, {1'b1, bytes[i], 1'b0});
            if (i == 1) begin
                n_tests++;
                if (dut2.ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_early: %b after 2 pushes, expected 0", dut2.ovf);
                end
            end
        end
        idle(20);
        n_tests++;
        if (dut2.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: %b after 4 pushes, expected 1", dut2.ovf);
        end
        release dut2.tx_pop;
        wait_frames(1, 2, 1000, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_drain_count: %0d frames, expected 2", got2_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (got2_q.size() > 0 && exp2_q.size() > 0) begin
                g = got2_q.pop_front();
                e = exp2_q.pop_front();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL ovf_drain[%0d]: got %h, expected %h", i, g, e);
                end
            end
        end
        idle(300);
        n_tests++;
        if (got2_q.size() !== 0 || dut2.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_tail: extra frames=%0d ovf=%b, expected 0 and 1", got2_q.size(), dut2.ovf);
        end
    endtask

    task automatic test_glitch_reset();
        int rxv0;
        rxv0 = rxv_cnt;
        usb_rx = 1'b0;
        idle(CPB / 2 - 10);
        usb_rx = 1'b1;
        idle(1500);
        n_tests++;
        if (rxv_cnt !== rxv0 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch: rx_valid count=%0d echoes=%0d, expected %0d and 0", rxv_cnt, got_q.size(), rxv0);
        end
        send_frame(0, CPB, {1'b1, 8'h00, 1'b0});
        idle(100);
        n_tests++;
        if (usb_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_busy_pre_reset: usb_tx=%b, expected 0 mid frame", usb_tx);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (usb_tx !== 1'b1 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_frame: usb_tx=%b led=%h, expected 1 and 00", usb_tx, led);
        end
        idle(5);
        rst_n = 1'b1;
        idle(1200);
        n_tests++;
        if (dut.fifo_empty !== 1'b1 || got_q.size() !== 0 || usb_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: fifo_empty=%b echoes=%0d usb_tx=%b, expected 1 0 1",
                     dut.fifo_empty, got_q.size(), usb_tx);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        usb_rx = 1'b1;
        usb_rx2 = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_overflow();
        test_glitch_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
